cam_capture: RTL and testbench

- Upstream stage of the VGA path. Drives the camera master clock (xclk) and samples the camera's vref/href/8-bit data bus.
- Decimates the incoming frame to a GRID_W x GRID_H luma grid.
- Emits one registered write per grid cell into the frame store that the video generator reads.
- Single clock domain (clk). The camera's pixel timing is derived from xclk, so no pclk input is needed.

---
 rtl/cam_pkg.sv | 26 ++
 rtl/cam_capture_if.sv | 50 +++++
 rtl/cam_sync.sv | 26 ++
 rtl/cam_capture.sv | 234 +++++++++++++++++++++++
 tb/tb_cam_capture.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cam_pkg.sv
// Shared types and elaboration-time helpers for the camera capture front end.
package cam_pkg;

    typedef enum logic [1:0] {
        WAIT_VSYNC,
        WAIT_FRAME,
        ACTIVE,
        DONE
    } cam_state_t;

    // Grid indices run one past the last cell so remainder pixels can be
    // walked without wrapping back into the grid.
    localparam int unsigned GridCoordW = 8;
    typedef logic [GridCoordW-1:0] grid_coord_t;

    typedef logic [7:0] luma_t;

    function automatic int unsigned step_of(input int unsigned src, input int unsigned grid);
        return src / grid;
    endfunction

    function automatic int unsigned addr_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cam_capture_if.sv
// Camera pins plus the frame-store write port and frame status of cam_capture.
interface cam_capture_if #(
    parameter int unsigned GRID_W = 15,
    parameter int unsigned GRID_H = 15
) ();

    localparam int unsigned AxW = cam_pkg::addr_w(GRID_W);
    localparam int unsigned AyW = cam_pkg::addr_w(GRID_H);

    logic           href;
    logic           vref;
    logic [7:0]     digital;
    logic           xclk;
    logic           we;
    logic [AxW-1:0] waddr_x;
    logic [AyW-1:0] waddr_y;
    logic [7:0]     wdata;
    logic           frame_done;
    logic           frame_err;
    logic           busy;

    modport slave (
        input  href,
        input  vref,
        input  digital,
        output xclk,
        output we,
        output waddr_x,
        output waddr_y,
        output wdata,
        output frame_done,
        output frame_err,
        output busy
    );

    modport master (
        output href,
        output vref,
        output digital,
        input  xclk,
        input  we,
        input  waddr_x,
        input  waddr_y,
        input  wdata,
        input  frame_done,
        input  frame_err,
        input  busy
    );

endinterface

// File: rtl/cam_sync.sv
// Two-flop synchroniser for camera inputs, cleared by the async reset.
module cam_sync #(
    parameter int unsigned Width = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] meta_q;
    logic [Width-1:0] sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/cam_capture.sv
// Camera capture: drives xclk, samples href/vref/data and writes a decimated
// luma grid into the frame store, one registered write per grid cell.
module cam_capture
    import cam_pkg::*;
#(
    parameter int unsigned GRID_W = 15,
    parameter int unsigned GRID_H = 15,
    parameter int unsigned SRC_W  = 640,
    parameter int unsigned SRC_H  = 480,
    parameter int unsigned BPP    = 2,
    parameter int unsigned Y_BYTE = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    cam_capture_if.slave bus_io
);

    localparam int unsigned STEP_X = step_of(SRC_W, GRID_W);
    localparam int unsigned STEP_Y = step_of(SRC_H, GRID_H);
    localparam int unsigned AxW    = addr_w(GRID_W);
    localparam int unsigned AyW    = addr_w(GRID_H);
    localparam int unsigned ColW   = $clog2(SRC_W + 1);
    localparam int unsigned LineW  = $clog2(SRC_H + 1);
    localparam int unsigned ByteW  = $clog2(BPP + 1);
    localparam int unsigned SxW    = $clog2(STEP_X + 1);
    localparam int unsigned SyW    = $clog2(STEP_Y + 1);

    localparam logic [ColW-1:0]  ColEnd   = ColW'(SRC_W);
    localparam logic [LineW-1:0] LineLast = LineW'(SRC_H - 1);
    localparam logic [ByteW-1:0] ByteLast = ByteW'(BPP - 1);
    localparam logic [ByteW-1:0] YByte    = ByteW'(Y_BYTE);
    localparam logic [SxW-1:0]   SxLast   = SxW'(STEP_X - 1);
    localparam logic [SyW-1:0]   SyLast   = SyW'(STEP_Y - 1);
    localparam grid_coord_t      GridW    = grid_coord_t'(GRID_W);
    localparam grid_coord_t      GridH    = grid_coord_t'(GRID_H);

    logic  href_s;
    logic  vref_s;
    luma_t digital_s;

    cam_sync #(.Width(1)) u_sync_href (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (bus_io.href),
        .q_o     (href_s)
    );

    cam_sync #(.Width(1)) u_sync_vref (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (bus_io.vref),
        .q_o     (vref_s)
    );

    cam_sync #(.Width(8)) u_sync_data (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (bus_io.digital),
        .q_o     (digital_s)
    );

    logic xclk_q;
    logic xclk_d1_q;
    logic xclk_d2_q;
    logic smp;

    cam_state_t       state_q, state_d;
    logic [LineW-1:0] line_q, line_d;
    logic [ColW-1:0]  pix_col_q, pix_col_d;
    logic [ByteW-1:0] byte_idx_q, byte_idx_d;
    logic [SxW-1:0]   sx_q, sx_d;
    logic [SyW-1:0]   sy_q, sy_d;
    grid_coord_t      gx_q, gx_d;
    grid_coord_t      gy_q, gy_d;
    logic             href_prev_q, href_prev_d;
    logic             we_q, we_d;
    logic [AxW-1:0]   waddr_x_q, waddr_x_d;
    logic [AyW-1:0]   waddr_y_q, waddr_y_d;
    luma_t            wdata_q, wdata_d;
    logic             frame_err_q, frame_err_d;
    logic             hit;
    logic             href_fall;

    // xclk delayed by the synchroniser depth lines the strobe up with synced data
    assign smp = xclk_d2_q;

    always_comb begin
        state_d     = state_q;
        line_d      = line_q;
        pix_col_d   = pix_col_q;
        byte_idx_d  = byte_idx_q;
        sx_d        = sx_q;
        sy_d        = sy_q;
        gx_d        = gx_q;
        gy_d        = gy_q;
        href_prev_d = href_prev_q;
        we_d        = 1'b0;
        waddr_x_d   = waddr_x_q;
        waddr_y_d   = waddr_y_q;
        wdata_d     = wdata_q;
        frame_err_d = 1'b0;
        hit         = 1'b0;
        href_fall   = 1'b0;

        unique case (state_q)
            WAIT_VSYNC: begin
                if (smp && vref_s) state_d = WAIT_FRAME;
            end
            WAIT_FRAME: begin
                if (smp && !vref_s) begin
                    state_d     = ACTIVE;
                    line_d      = '0;
                    pix_col_d   = '0;
                    byte_idx_d  = '0;
                    sx_d        = '0;
                    sy_d        = '0;
                    gx_d        = '0;
                    gy_d        = '0;
                    href_prev_d = 1'b0;
                end
            end
            ACTIVE: begin
                if (smp) begin
                    href_prev_d = href_s;
                    // href_prev_q is only set by a sampled byte, so empty lines never count
                    href_fall   = href_prev_q && !href_s;
                    if (href_s) begin
                        if (pix_col_q < ColEnd) begin
                            hit = (sx_q == '0) && (sy_q == '0) && (byte_idx_q == YByte) &&
                                  (gx_q < GridW) && (gy_q < GridH);
                            if (byte_idx_q == ByteLast) begin
                                byte_idx_d = '0;
                                pix_col_d  = pix_col_q + ColW'(1);
                                if (sx_q == SxLast) begin
                                    sx_d = '0;
                                    if (gx_q < GridW) gx_d = gx_q + grid_coord_t'(1);
                                end else begin
                                    sx_d = sx_q + SxW'(1);
                                end
                            end else begin
                                byte_idx_d = byte_idx_q + ByteW'(1);
                            end
                        end
                    end else begin
                        byte_idx_d = '0;
                        pix_col_d  = '0;
                        sx_d       = '0;
                        gx_d       = '0;
                        if (href_fall) begin
                            line_d = line_q + LineW'(1);
                            if (sy_q == SyLast) begin
                                sy_d = '0;
                                if (gy_q < GridH) gy_d = gy_q + grid_coord_t'(1);
                            end else begin
                                sy_d = sy_q + SyW'(1);
                            end
                        end
                    end

                    // Completing the last line takes priority over a coincident vsync
                    if (href_fall && (line_q == LineLast)) begin
                        state_d = DONE;
                    end else if (vref_s) begin
                        state_d     = WAIT_FRAME;
                        frame_err_d = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = WAIT_VSYNC;
            end
            default: begin
                state_d = WAIT_VSYNC;
            end
        endcase

        if (hit) begin
            we_d      = 1'b1;
            waddr_x_d = gx_q[AxW-1:0];
            waddr_y_d = gy_q[AyW-1:0];
            wdata_d   = digital_s;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            xclk_q      <= 1'b0;
            xclk_d1_q   <= 1'b0;
            xclk_d2_q   <= 1'b0;
            state_q     <= WAIT_VSYNC;
            line_q      <= '0;
            pix_col_q   <= '0;
            byte_idx_q  <= '0;
            sx_q        <= '0;
            sy_q        <= '0;
            gx_q        <= '0;
            gy_q        <= '0;
            href_prev_q <= 1'b0;
            we_q        <= 1'b0;
            waddr_x_q   <= '0;
            waddr_y_q   <= '0;
            wdata_q     <= '0;
            frame_err_q <= 1'b0;
        end else begin
            xclk_q      <= ~xclk_q;
            xclk_d1_q   <= xclk_q;
            xclk_d2_q   <= xclk_d1_q;
            state_q     <= state_d;
            line_q      <= line_d;
            pix_col_q   <= pix_col_d;
            byte_idx_q  <= byte_idx_d;
            sx_q        <= sx_d;
            sy_q        <= sy_d;
            gx_q        <= gx_d;
            gy_q        <= gy_d;
            href_prev_q <= href_prev_d;
            we_q        <= we_d;
            waddr_x_q   <= waddr_x_d;
            waddr_y_q   <= waddr_y_d;
            wdata_q     <= wdata_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign bus_io.xclk       = xclk_q;
    assign bus_io.we         = we_q;
    assign bus_io.waddr_x    = waddr_x_q;
    assign bus_io.waddr_y    = waddr_y_q;
    assign bus_io.wdata      = wdata_q;
    assign bus_io.frame_done = (state_q == DONE);
    assign bus_io.frame_err  = frame_err_q;
    assign bus_io.busy       = (state_q == ACTIVE);

endmodule

// File: tb/tb_cam_capture.sv
// Randomised scoreboard bench for cam_capture on a 4x4 grid over an 8x8 source.
module tb_cam_capture;

    localparam int GW   = 4;
    localparam int GH   = 4;
    localparam int SW   = 8;
    localparam int SH   = 8;
    localparam int BPP  = 2;
    localparam int YB   = 1;
    localparam int SX   = SW / GW;
    localparam int SY   = SH / GH;
    localparam int MAXB = 24;

    typedef struct {
        int x;
        int y;
        int d;
    } wr_t;

    typedef struct {
        bit is_err;
        int writes;
    } ev_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    cam_capture_if #(.GRID_W(GW), .GRID_H(GH)) bus ();

    cam_capture #(
        .GRID_W (GW),
        .GRID_H (GH),
        .SRC_W  (SW),
        .SRC_H  (SH),
        .BPP    (BPP),
        .Y_BYTE (YB)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus_io  (bus)
    );

    int   total = 0;
    int   bad = 0;
    int   pushed = 0;
    int   seen = 0;
    wr_t  exp_q[$];
    ev_t  ev_q[$];
    wr_t  mon_w;
    ev_t  mon_e;
    logic prev_we = 1'b0;

    logic [7:0] fb[SH][MAXB];
    int         len_a[SH];

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Scoreboard monitor: every write and every frame event is matched in order.
    always @(negedge clk) begin
        if (bus.we) begin
            check("we_gap", int'(prev_we), 0);
            if (exp_q.size() == 0) begin
                check("unexpected_write", 1, 0);
            end else begin
                mon_w = exp_q.pop_front();
                check("waddr_x", int'(bus.waddr_x), mon_w.x);
                check("waddr_y", int'(bus.waddr_y), mon_w.y);
                check("wdata", int'(bus.wdata), mon_w.d);
            end
            seen++;
        end
        prev_we <= bus.we;
        if (bus.frame_done && bus.frame_err) begin
            check("done_err_overlap", 1, 0);
        end else if (bus.frame_done || bus.frame_err) begin
            if (ev_q.size() == 0) begin
                check("unexpected_frame_event", 1, 0);
            end else begin
                mon_e = ev_q.pop_front();
                check("frame_event_is_err", int'(bus.frame_err), int'(mon_e.is_err));
                check("writes_before_event", seen, mon_e.writes);
            end
        end
    end

    task automatic cam_cycle(input logic h, input logic v, input logic [7:0] d);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!bus.xclk && n < 4);
        if (!bus.xclk) begin
            total++;
            bad++;
            $display("FAIL xclk_stalled: got %0b, required 1", bus.xclk);
            $display("test done: total=%0d bad=%0d", total, bad);
            $fatal(1, "xclk stalled");
        end
        bus.href    = h;
        bus.vref    = v;
        bus.digital = d;
    endtask

    task automatic idle(input int n, input logic v);
        for (int i = 0; i < n; i++) cam_cycle(1'b0, v, 8'h00);
    endtask

    task automatic send_vsync(input int hi, input int lo);
        idle(hi, 1'b1);
        idle(lo, 1'b0);
    endtask

    task automatic send_lines(input int n, input int last_gap);
        for (int l = 0; l < n; l++) begin
            for (int b = 0; b < len_a[l]; b++) cam_cycle(1'b1, 1'b0, fb[l][b]);
            idle((l == n - 1) ? last_gap : int'($urandom_range(1, 3)), 1'b0);
        end
    endtask

    task automatic fill_pattern();
        for (int l = 0; l < SH; l++) begin
            len_a[l] = SW * BPP;
            for (int b = 0; b < MAXB; b++) fb[l][b] = 8'(l * 16 + b);
        end
    endtask

    task automatic fill_random();
        for (int l = 0; l < SH; l++) begin
            len_a[l] = int'($urandom_range(1, 20));
            for (int b = 0; b < MAXB; b++) fb[l][b] = 8'($urandom);
        end
    endtask

    // Reference: every STEP-th pixel of every STEP-th line, if its luma byte was sent.
    task automatic predict(input int nlines);
        wr_t w;
        for (int l = 0; l < nlines; l++) begin
            if ((l % SY) != 0 || (l / SY) >= GH) continue;
            for (int p = 0; p < SW; p += SX) begin
                if ((p / SX) < GW && (p * BPP + YB) < len_a[l]) begin
                    w.x = p / SX;
                    w.y = l / SY;
                    w.d = int'(fb[l][p * BPP + YB]);
                    exp_q.push_back(w);
                    pushed++;
                end
            end
        end
    endtask

    task automatic expect_event(input bit is_err);
        ev_t e;
        e.is_err = is_err;
        e.writes = pushed;
        ev_q.push_back(e);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || ev_q.size() != 0) && n < 400) begin
            @(posedge clk);
            n++;
        end
        check({name, "_drained"}, exp_q.size() + ev_q.size(), 0);
        if (exp_q.size() != 0 || ev_q.size() != 0) begin
            exp_q.delete();
            ev_q.delete();
            seen = pushed;
        end
    endtask

    initial begin
        bus.href    = 1'b0;
        bus.vref    = 1'b0;
        bus.digital = 8'h00;

        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_xclk", int'(bus.xclk), 0);
        check("rst_we", int'(bus.we), 0);
        check("rst_waddr_x", int'(bus.waddr_x), 0);
        check("rst_waddr_y", int'(bus.waddr_y), 0);
        check("rst_wdata", int'(bus.wdata), 0);
        check("rst_frame_done", int'(bus.frame_done), 0);
        check("rst_frame_err", int'(bus.frame_err), 0);
        check("rst_busy", int'(bus.busy), 0);
        reset_n = 1'b1;
        @(negedge clk);
        check("xclk_edge1", int'(bus.xclk), 1);
        @(negedge clk);
        check("xclk_edge2", int'(bus.xclk), 0);
        @(negedge clk);
        check("xclk_edge3", int'(bus.xclk), 1);

        // Full patterned frame
        fill_pattern();
        predict(SH);
        expect_event(1'b0);
        send_vsync(int'($urandom_range(1, 3)), int'($urandom_range(1, 3)));
        send_lines(SH, 2);
        wait_drain("full_frame");

        // Short frame: vsync arrives in place of line 4, then a normal frame
        fill_pattern();
        predict(4);
        send_vsync(2, 1);
        send_lines(4, 2);
        expect_event(1'b1);
        predict(SH);
        expect_event(1'b0);
        send_vsync(2, 2);
        send_lines(SH, 2);
        wait_drain("short_frame");

        // Over-long line 0 and short line 2
        fill_pattern();
        len_a[0] = 20;
        len_a[2] = 6;
        predict(SH);
        expect_event(1'b0);
        send_vsync(1, 1);
        send_lines(SH, 2);
        wait_drain("long_short_lines");

        // Async reset part-way through line 3
        fill_pattern();
        predict(3);
        send_vsync(1, 1);
        send_lines(3, 1);
        for (int b = 0; b < 4; b++) cam_cycle(1'b1, 1'b0, fb[3][b]);
        wait_drain("pre_reset");
        @(negedge clk);
        check("busy_before_reset", int'(bus.busy), 1);
        reset_n = 1'b0;
        #1;
        check("reset_busy_async", int'(bus.busy), 0);
        check("reset_xclk_async", int'(bus.xclk), 0);
        check("reset_we_async", int'(bus.we), 0);
        bus.href = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        send_lines(2, 2);
        repeat (10) @(posedge clk);
        check("idle_after_reset_busy", int'(bus.busy), 0);
        predict(SH);
        expect_event(1'b0);
        send_vsync(1, 1);
        send_lines(SH, 2);
        wait_drain("after_reset_frame");

        // Back-to-back frames with minimal gaps
        fill_pattern();
        predict(SH);
        expect_event(1'b0);
        send_vsync(1, 1);
        send_lines(SH, 1);
        fill_random();
        predict(SH);
        expect_event(1'b0);
        send_vsync(1, 1);
        send_lines(SH, 2);
        wait_drain("back_to_back");

        // Random data and line lengths
        for (int f = 0; f < 3; f++) begin
            fill_random();
            predict(SH);
            expect_event(1'b0);
            send_vsync(int'($urandom_range(1, 3)), int'($urandom_range(1, 3)));
            send_lines(SH, int'($urandom_range(1, 3)));
            wait_drain("random_frame");
        end

        repeat (10) @(posedge clk);
        check("total_writes", seen, pushed);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
